// File: rtl/tile_map_mem.sv
`default_nettype none
// ============================================================================
// Module   : tile_map_mem
// Purpose  : Light-cycle tile map. Holds one tile code per map cell, clears
//            itself to an empty arena with a wall border, takes head writes
//            from the game FSM with a read-first collision report, and serves
//            the VGA draw path through a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module tile_map_mem #(
    parameter int MAP_W     = 64,
    parameter int MAP_H     = 48,
    parameter int N_PLAYERS = 2,
    parameter int X_W       = $clog2(MAP_W),
    parameter int Y_W       = $clog2(MAP_H),
    parameter int P_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
    parameter int TILE_W    = $clog2(N_PLAYERS + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [P_W-1:0]    wr_player,
    output logic              collision,
    output logic [TILE_W-1:0] collision_tile,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic [TILE_W-1:0] rd_tile
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_CELLS  = MAP_W * MAP_H;
    localparam int                c_A_W    = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;
    localparam logic [TILE_W-1:0] c_EMPTY  = '0;
    localparam logic [TILE_W-1:0] c_FRAME  = TILE_W'(N_PLAYERS + 1);
    localparam logic [X_W-1:0]    c_X_LAST = X_W'(MAP_W - 1);
    localparam logic [Y_W-1:0]    c_Y_LAST = Y_W'(MAP_H - 1);

    // Sweep controller states. TAIL is the extra busy cycle after the last
    // cell is written, so busy always drops one edge after the final write.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWEEP = 2'd1;
    localparam logic [1:0] c_ST_TAIL  = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [TILE_W-1:0] r_mem [c_CELLS];

    logic [1:0]        r_state;
    logic              r_busy;
    logic [X_W-1:0]    r_sx;
    logic [Y_W-1:0]    r_sy;

    // Collision pipeline: stage one holds the read-first old content,
    // stage two is the registered output pulse.
    logic              r_p_hit;
    logic [TILE_W-1:0] r_p_tile;
    logic              r_coll;
    logic [TILE_W-1:0] r_coll_tile;

    logic [TILE_W-1:0] r_rd_tile;

    // ------------------------------------------------------------------------
    // Range checks. When a dimension fills its coordinate field exactly the
    // compare is always true, so it is elided to keep the logic constant-free.
    // ------------------------------------------------------------------------
    logic w_wr_x_ok;
    logic w_rd_x_ok;
    logic w_wr_y_ok;
    logic w_rd_y_ok;
    logic w_player_ok;

    generate
        if (MAP_W == (1 << X_W)) begin : g_x_full
            assign w_wr_x_ok = 1'b1;
            assign w_rd_x_ok = 1'b1;
        end else begin : g_x_part
            assign w_wr_x_ok = (32'(wr_x) < MAP_W);
            assign w_rd_x_ok = (32'(rd_x) < MAP_W);
        end

        if (MAP_H == (1 << Y_W)) begin : g_y_full
            assign w_wr_y_ok = 1'b1;
            assign w_rd_y_ok = 1'b1;
        end else begin : g_y_part
            assign w_wr_y_ok = (32'(wr_y) < MAP_H);
            assign w_rd_y_ok = (32'(rd_y) < MAP_H);
        end

        if (N_PLAYERS == (1 << P_W)) begin : g_player_full
            assign w_player_ok = 1'b1;
        end else begin : g_player_part
            assign w_player_ok = (32'(wr_player) < N_PLAYERS);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Address generation (row-major, x fastest)
    // ------------------------------------------------------------------------
    logic [c_A_W-1:0] w_wr_addr;
    logic [c_A_W-1:0] w_rd_addr;
    logic [c_A_W-1:0] w_sweep_addr;

    assign w_wr_addr    = c_A_W'(wr_y) * c_A_W'(MAP_W) + c_A_W'(wr_x);
    assign w_rd_addr    = c_A_W'(rd_y) * c_A_W'(MAP_W) + c_A_W'(rd_x);
    assign w_sweep_addr = c_A_W'(r_sy) * c_A_W'(MAP_W) + c_A_W'(r_sx);

    // ------------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------------
    logic              w_wr_in_range;
    logic              w_wr_accept;
    logic              w_wr_do;
    logic              w_wr_mem_we;
    logic [TILE_W-1:0] w_wr_tile;
    logic [TILE_W-1:0] w_wr_old;

    assign w_wr_in_range = w_wr_x_ok & w_wr_y_ok;
    assign w_wr_accept   = wr_valid & ~r_busy;
    // Invalid player indices are dropped entirely: no write and no pulse.
    assign w_wr_do       = w_wr_accept & w_player_ok;
    assign w_wr_mem_we   = w_wr_do & w_wr_in_range;
    assign w_wr_tile     = TILE_W'(wr_player) + TILE_W'(1);
    // Off-map heads behave as if they ran into the wall.
    assign w_wr_old      = w_wr_in_range ? r_mem[w_wr_addr] : c_FRAME;

    // ------------------------------------------------------------------------
    // Sweep-side decode. A clear request on the same edge restarts the sweep
    // without writing, so cell (0,0) is always the first cell written.
    // ------------------------------------------------------------------------
    logic              w_sweep_we;
    logic              w_sweep_last;
    logic              w_sweep_border;
    logic [TILE_W-1:0] w_sweep_tile;

    assign w_sweep_we     = (r_state == c_ST_SWEEP) & ~clear_req;
    assign w_sweep_last   = (r_sx == c_X_LAST) & (r_sy == c_Y_LAST);
    assign w_sweep_border = (r_sx == '0) | (r_sx == c_X_LAST) |
                            (r_sy == '0) | (r_sy == c_Y_LAST);
    assign w_sweep_tile   = w_sweep_border ? c_FRAME : c_EMPTY;

    // Sweep controller: restarts on reset or clear_req, walks every cell once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_SWEEP;
            r_busy  <= 1'b1;
            r_sx    <= '0;
            r_sy    <= '0;
        end else if (clear_req) begin
            r_state <= c_ST_SWEEP;
            r_busy  <= 1'b1;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            case (r_state)
                c_ST_SWEEP: begin
                    if (w_sweep_last) begin
                        r_state <= c_ST_TAIL;
                        r_sx    <= '0;
                        r_sy    <= '0;
                    end else if (r_sx == c_X_LAST) begin
                        r_sx <= '0;
                        r_sy <= r_sy + 1'b1;
                    end else begin
                        r_sx <= r_sx + 1'b1;
                    end
                end
                c_ST_TAIL: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                c_ST_IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Map storage: sweep and head writes are mutually exclusive via busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweep_we) begin
                r_mem[w_sweep_addr] <= w_sweep_tile;
            end else if (w_wr_mem_we) begin
                r_mem[w_wr_addr] <= w_wr_tile;
            end
        end
    end

    // Collision pipeline: capture old content at accept, present it one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_hit     <= 1'b0;
            r_p_tile    <= c_EMPTY;
            r_coll      <= 1'b0;
            r_coll_tile <= c_EMPTY;
        end else begin
            r_p_hit     <= w_wr_do & (w_wr_old != c_EMPTY);
            r_p_tile    <= (w_wr_do & (w_wr_old != c_EMPTY)) ? w_wr_old : c_EMPTY;
            r_coll      <= r_p_hit;
            r_coll_tile <= r_p_hit ? r_p_tile : c_EMPTY;
        end
    end

    // Draw-path read port: registered, returns pre-write content on a same-cell hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_tile <= c_EMPTY;
        end else begin
            r_rd_tile <= (w_rd_x_ok & w_rd_y_ok) ? r_mem[w_rd_addr] : c_EMPTY;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy           = r_busy;
    assign wr_ready       = ~r_busy;
    assign collision      = r_coll;
    assign collision_tile = r_coll_tile;
    assign rd_tile        = r_rd_tile;

endmodule

`default_nettype wire

// File: tb/tb_tile_map_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_map_mem
// Purpose  : Self-checking bench for tile_map_mem. A driver issues writes and
//            reads against an array model of the map and queues the expected
//            collision and read results; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_map_mem;

    localparam int MAP_W     = 64;
    localparam int MAP_H     = 48;
    localparam int N_PLAYERS = 2;
    localparam int X_W       = 6;
    localparam int Y_W       = 6;
    localparam int P_W       = 1;
    localparam int TILE_W    = 2;
    localparam int c_CELLS   = MAP_W * MAP_H;
    localparam int c_FRAME   = N_PLAYERS + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear_req;
    logic              busy;
    logic              wr_valid;
    logic              wr_ready;
    logic [X_W-1:0]    wr_x;
    logic [Y_W-1:0]    wr_y;
    logic [P_W-1:0]    wr_player;
    logic              collision;
    logic [TILE_W-1:0] collision_tile;
    logic [X_W-1:0]    rd_x;
    logic [Y_W-1:0]    rd_y;
    logic [TILE_W-1:0] rd_tile;

    always #5 clk = ~clk;

    tile_map_mem #(
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H),
        .N_PLAYERS (N_PLAYERS)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .clear_req      (clear_req),
        .busy           (busy),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_player      (wr_player),
        .collision      (collision),
        .collision_tile (collision_tile),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_tile        (rd_tile)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    int model [MAP_H][MAP_W];

    typedef struct { int due; int coll; int tile; } coll_exp_t;
    typedef struct { int due; int tile; } rd_exp_t;
    coll_exp_t cq[$];
    rd_exp_t   rq[$];

    // Edge counter: value seen at a negedge is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Freshly cleared arena: wall on the outer ring, empty inside.
    function automatic void model_clear();
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                model[y][x] = (x == 0 || x == MAP_W-1 || y == 0 || y == MAP_H-1) ? c_FRAME : 0;
    endfunction

    function automatic int model_read(input int x, input int y);
        if (x >= MAP_W || y >= MAP_H) return 0;
        return model[y][x];
    endfunction

    // One idle-map cycle of stimulus. Expectations are queued against the edge
    // that samples these inputs; the read is resolved before the write is
    // applied so a same-cell read sees the old content.
    task automatic step(input bit wv, input int wx, input int wy, input int wp,
                        input bit rchk, input int rx, input int ry);
        int        e_edge;
        int        old;
        coll_exp_t ce;
        rd_exp_t   re;
        e_edge    = cyc + 1;
        wr_valid  = wv;
        wr_x      = X_W'(wx);
        wr_y      = Y_W'(wy);
        wr_player = P_W'(wp);
        rd_x      = X_W'(rx);
        rd_y      = Y_W'(ry);
        if (rchk) begin
            re.due  = e_edge;
            re.tile = model_read(rx, ry);
            rq.push_back(re);
        end
        if (wv) begin
            old     = (wx < MAP_W && wy < MAP_H) ? model[wy][wx] : c_FRAME;
            ce.due  = e_edge + 1;
            ce.coll = (old != 0) ? 1 : 0;
            ce.tile = (old != 0) ? old : 0;
            cq.push_back(ce);
            if (wx < MAP_W && wy < MAP_H) model[wy][wx] = wp + 1;
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Counts busy cycles at negedges while hammering the write port, which
    // must be ignored throughout. Bounded in case busy never falls.
    task automatic count_busy(output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            clear_req = 1'b0;
            if (!busy) break;
            cnt++;
            if (cnt > c_CELLS + 100) begin
                chk("busy_timeout", 32'(cnt), 32'(c_CELLS));
                break;
            end
            wr_valid  = 1'($urandom);
            wr_x      = X_W'($urandom);
            wr_y      = Y_W'($urandom);
            wr_player = P_W'($urandom);
        end
        wr_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},     32'(busy), 32'd1);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        chk({tag, "_coll"},     32'(collision), 32'd0);
        chk({tag, "_coll_tile"},32'(collision_tile), 32'd0);
        chk({tag, "_rd_tile"},  32'(rd_tile), 32'd0);
    endtask

    // Monitor: pops expectations when due; any collision activity with no
    // queued expectation is an error.
    always @(negedge clk) begin : p_mon
        coll_exp_t e_c;
        rd_exp_t   e_r;
        if (mon_en) begin
            if (cq.size() > 0 && cq[0].due == cyc) begin
                e_c = cq.pop_front();
                chk("collision", 32'(collision), 32'(e_c.coll));
                chk("collision_tile", 32'(collision_tile), 32'(e_c.tile));
            end else if (collision !== 1'b0 || collision_tile !== '0) begin
                chk("spurious_collision", 32'({collision, collision_tile}), 32'd0);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_r = rq.pop_front();
                chk("rd_tile", 32'(rd_tile), 32'(e_r.tile));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_drv
        int cnt;
        int hx;
        int hy;
        rst = 1'b1; clear_req = 1'b0; wr_valid = 1'b0;
        wr_x = '0; wr_y = '0; wr_player = '0; rd_x = '0; rd_y = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk_reset_vals("init_reset");

        // Release: sweep runs exactly one cycle per cell.
        rst = 1'b0;
        count_busy(cnt);
        chk("busy_cycles_after_reset", 32'(cnt), 32'(c_CELLS));
        model_clear();
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);

        // Corner, interior and out-of-range reads.
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 63, 47);
        step(0, 0, 0, 0, 1, 10, 10);
        step(0, 0, 0, 0, 1, 5, 50);

        // Fresh cell, repeat hit, wall hit, off-map head.
        step(1, 10, 10, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10, 10);
        step(1, 10, 10, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10, 10);
        step(1, 0, 5, 0, 0, 0, 0);
        step(1, 7, 50, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7, 47);
        // Back-to-back same cell, and read/write of the same cell on one edge.
        step(1, 20, 20, 0, 0, 0, 0);
        step(1, 20, 20, 1, 1, 20, 20);
        step(1, 30, 30, 1, 1, 30, 30);
        step(0, 0, 0, 0, 1, 30, 30);

        // Randomized play: a small hot region forces frequent collisions.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                hx = $urandom_range(8, 11);
                hy = $urandom_range(8, 11);
            end else begin
                hx = $urandom_range(0, MAP_W-1);
                hy = $urandom_range(0, 55);
            end
            step($urandom_range(0, 3) != 0, hx, hy, $urandom_range(0, N_PLAYERS-1),
                 1, $urandom_range(0, MAP_W-1), $urandom_range(0, 55));
        end

        // Mid-game clear: full sweep plus the request cycle, then a full scan.
        clear_req = 1'b1;
        count_busy(cnt);
        chk("busy_cycles_clear", 32'(cnt), 32'(c_CELLS + 1));
        model_clear();
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                step(0, 0, 0, 0, 1, x, y);

        // Dirty a few cells, then restart a clear partway through its sweep.
        for (int i = 0; i < 20; i++)
            step(1, $urandom_range(1, MAP_W-2), $urandom_range(1, MAP_H-2), $urandom_range(0, 1), 0, 0, 0);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("busy_mid_sweep", 32'(busy), 32'd1);
        clear_req = 1'b1;
        count_busy(cnt);
        chk("busy_cycles_restart", 32'(cnt), 32'(c_CELLS + 1));
        model_clear();
        for (int i = 0; i < 200; i++)
            step(0, 0, 0, 0, 1, $urandom_range(0, MAP_W-1), $urandom_range(0, MAP_H-1));

        // Reset lands on the edge that would present a wall collision.
        step(1, 0, 3, 0, 0, 0, 0);
        rst = 1'b1;
        cq.delete();
        rq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals("mid_write_reset");
        end
        rst = 1'b0;
        count_busy(cnt);
        chk("busy_cycles_rereset", 32'(cnt), 32'(c_CELLS));
        model_clear();
        step(1, 40, 40, 1, 1, 0, 3);
        step(1, 40, 40, 0, 1, 40, 40);
        step(0, 0, 0, 0, 1, 40, 40);

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("coll_queue_drained", 32'(cq.size()), 32'd0);
        chk("rd_queue_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
